lisnoc_vc_serializer: RTL
=========================

LISNOC_VC_SERIALIZER -- requirements
Module: lisnoc_vc_serializer

Interface
REQ-001 SHALL have parameter flit_data_width, default 32, flit payload bits.
REQ-002 SHALL have parameter flit_type_width, default 2, flit type bits at the flit MSBs.
REQ-003 SHALL have parameters FLIT_TYPE_HEADER=2'b01, FLIT_TYPE_PAYLOAD=2'b00, FLIT_TYPE_LAST=2'b10, FLIT_TYPE_SINGLE=2'b11, type encodings.
REQ-004 SHALL have parameter vchannels, default 2, number of input virtual channels; local flit_width = flit_data_width+flit_type_width.
REQ-005 SHALL have ports, in this order:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flit_i  input  vchannels*flit_width  per-VC flits; VC i at bits [i*flit_width +: flit_width].
- valid_i  input  vchannels  per-VC flit valid.
- ready_for_input  output  vchannels  per-VC accept.
- flit_o  output  flit_width  serialized flit (registered).
- valid_o  output  1  serialized valid (registered).
- ready_for_output  input  1  downstream accept.

Function
REQ-006 SHALL merge the vchannels input VCs onto one output link, packet-atomic: once a packet's first flit is taken from a VC, no other VC's flits are taken until that packet's LAST flit is taken.
REQ-007 SHALL implement FSM states IDLE (no packet open) and LOCKED (packet open on registered VC sel).
REQ-008 SHALL define can_load = !valid_o || ready_for_output.
REQ-009 In IDLE, candidates SHALL be the VCs with valid_i=1 and flit type HEADER or SINGLE; winner gnt chosen combinationally by round-robin, starting at VC (last+1) mod vchannels, where last is the VC of the most recently completed packet.
REQ-010 In IDLE, VCs presenting PAYLOAD or LAST SHALL NOT be granted; they stall indefinitely.
REQ-011 In LOCKED, gnt SHALL equal sel regardless of other VCs' valid_i.
REQ-012 ready_for_input SHALL be one-hot at gnt when can_load and (LOCKED, or IDLE with a candidate present), else all zero.
REQ-013 A transfer SHALL occur when valid_i[gnt] && ready_for_input[gnt]; at the next edge flit_o <= flit_i of gnt, valid_o <= 1.
REQ-014 On transfer of a HEADER or PAYLOAD flit, next state SHALL be LOCKED with sel <= gnt.
REQ-015 On transfer of a LAST or SINGLE flit, next state SHALL be IDLE with last <= gnt.
REQ-016 With no transfer and ready_for_output=1, valid_o SHALL clear at the next edge; with no transfer and ready_for_output=0, flit_o/valid_o SHALL hold.
REQ-017 Latency input->output SHALL be 1 cycle; sustained throughput 1 flit/cycle, including back-to-back packets from different VCs (no IDLE bubble, since IDLE arbitration is same-cycle).
REQ-018 flit_o SHALL be stable while valid_o=1 and ready_for_output=0.
REQ-019 In LOCKED with valid_i[sel]=0, output SHALL drain and the FSM SHALL stay LOCKED (gaps within packets allowed).

Reset
REQ-020 On rst=1 (asynchronous): valid_o=0, flit_o=0, state=IDLE, sel=0, last=vchannels-1 (VC 0 has first priority); ready_for_input=0 while rst asserted.
REQ-021 Reset mid-packet SHALL discard the open packet; after release, arbitration restarts per REQ-009.

Verification
REQ-022 Single-flit: VC1 presents SINGLE 0x3_00000005, ready_for_output=1 -> ready_for_input=2'b10 same cycle; next cycle flit_o=0x3_00000005, valid_o=1; following cycle valid_o=0.
REQ-023 Atomicity: VC0 sends HEADER,PAYLOAD,LAST while VC1 holds HEADER valid throughout -> output order VC0 H,P,L then VC1 H; ready_for_input[1]=0 until the VC0 LAST cycle.
REQ-024 Fairness: both VCs send continuous 2-flit packets after reset -> packets alternate VC0,VC1,VC0,VC1 with valid_o=1 every cycle.
REQ-025 Backpressure: ready_for_output=0 for 3 cycles with valid_o=1 -> flit_o unchanged, ready_for_input=0; on release 1 flit/cycle resumes, no loss or duplication.
REQ-026 Illegal start: in IDLE VC0 presents PAYLOAD, VC1 nothing -> ready_for_input=0, valid_o=0 indefinitely.
REQ-027 Async reset mid-packet: assert rst between clock edges after VC0 HEADER -> valid_o=0 immediately; after release VC1 HEADER is granted without VC0 LAST.

Source files
------------

// File: rtl/lisnoc_vc_serializer.sv
// Virtual-channel serializer: merges several input virtual channels onto a
// single output link. Packets are kept atomic: once the first flit of a
// packet has been taken from a VC, that VC owns the link until its LAST
// flit has been taken. New packets are picked by round-robin arbitration
// starting after the VC that completed the most recent packet.
module lisnoc_vc_serializer #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter logic [flit_type_width-1:0] FLIT_TYPE_HEADER  = 2'b01,
   parameter logic [flit_type_width-1:0] FLIT_TYPE_PAYLOAD = 2'b00,
   parameter logic [flit_type_width-1:0] FLIT_TYPE_LAST    = 2'b10,
   parameter logic [flit_type_width-1:0] FLIT_TYPE_SINGLE  = 2'b11,
   parameter int vchannels = 2
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [vchannels*(flit_data_width+flit_type_width)-1:0] flit_i,
   input  logic [vchannels-1:0]                                  valid_i,
   output logic [vchannels-1:0]                                  ready_for_input,
   output logic [flit_data_width+flit_type_width-1:0]            flit_o,
   output logic                                                  valid_o,
   input  logic                                                  ready_for_output
);

   localparam int flit_width = flit_data_width + flit_type_width;
   // Width of a VC index; at least one bit so a single-VC build still elaborates.
   localparam int vc_w = (vchannels > 1) ? $clog2(vchannels) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                 state_reg;
   state_t                 state_next;
   logic [vc_w-1:0]        sel_reg;
   logic [vc_w-1:0]        sel_next;
   logic [vc_w-1:0]        last_reg;
   logic [vc_w-1:0]        last_next;

   logic [flit_width-1:0]  flit_reg;
   logic                   valid_reg;

   // Per-VC views of the flattened input bus.
   logic [flit_width-1:0]      vc_flit [vchannels];
   logic [flit_type_width-1:0] vc_type [vchannels];
   logic [vchannels-1:0]       cand;

   // Arbitration results.
   logic [vc_w-1:0]        rr_gnt;
   logic                   rr_found;
   logic [vc_w-1:0]        rr_idx;
   logic [vc_w-1:0]        gnt;
   logic                   have_grant;
   logic                   can_load;

   // Selected-VC datapath.
   logic [flit_width-1:0]      gnt_flit;
   logic [flit_type_width-1:0] gnt_type;
   logic                       gnt_valid;
   logic                       xfer;
   logic                       gnt_keeps_open;

   // Split the input bus and flag VCs that may start a new packet.
   generate
      for (genvar gi = 0; gi < vchannels; gi++) begin : g_vc
         assign vc_flit[gi] = flit_i[gi*flit_width +: flit_width];
         assign vc_type[gi] = vc_flit[gi][flit_width-1 -: flit_type_width];
         // Only packet openers compete in IDLE; a stray PAYLOAD/LAST waits forever.
         assign cand[gi]    = valid_i[gi] &&
                              ((vc_type[gi] == FLIT_TYPE_HEADER) ||
                               (vc_type[gi] == FLIT_TYPE_SINGLE));
      end
   endgenerate

   // Round-robin search for a packet opener, starting after the last winner.
   always_comb begin
      rr_gnt   = last_reg;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= vchannels; k++) begin
         rr_idx = vc_w'((int'(last_reg) + k) % vchannels);
         if (!rr_found && cand[rr_idx]) begin
            rr_gnt   = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   // An open packet pins the grant to its VC; otherwise use the arbiter.
   assign gnt        = (state_reg == LOCKED) ? sel_reg : rr_gnt;
   assign have_grant = (state_reg == LOCKED) || rr_found;

   // The output register can take a flit when empty or being drained now.
   assign can_load   = !valid_reg || ready_for_output;

   // One-hot accept at the granted VC; held low while reset is asserted.
   generate
      for (genvar gi = 0; gi < vchannels; gi++) begin : g_ready
         assign ready_for_input[gi] = !rst && can_load && have_grant &&
                                      (gnt == vc_w'(gi));
      end
   endgenerate

   assign gnt_flit       = vc_flit[gnt];
   assign gnt_type       = vc_type[gnt];
   assign gnt_valid      = valid_i[gnt];
   assign xfer           = gnt_valid && ready_for_input[gnt];
   // HEADER and PAYLOAD leave the packet open; LAST and SINGLE close it.
   assign gnt_keeps_open = (gnt_type == FLIT_TYPE_HEADER) ||
                           (gnt_type == FLIT_TYPE_PAYLOAD);

   // Next-state logic: packet open/close decisions happen only on a transfer.
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      last_next  = last_reg;
      if (xfer) begin
         if (gnt_keeps_open) begin
            state_next = LOCKED;
            sel_next   = gnt;
         end else begin
            state_next = IDLE;
            last_next  = gnt;
         end
      end
   end

   // FSM state, locked VC and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         last_reg  <= vc_w'(vchannels - 1);
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         last_reg  <= last_next;
      end
   end

   // Output register: load on transfer, drain when accepted, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (xfer) begin
         flit_reg  <= gnt_flit;
         valid_reg <= 1'b1;
      end else if (ready_for_output) begin
         valid_reg <= 1'b0;
      end
   end

   assign flit_o  = flit_reg;
   assign valid_o = valid_reg;

endmodule
